// File: rtl/nios_project_button_pio_pkg.sv
// Shared constants for the button PIO: register word addresses and edge-capture modes.
package nios_project_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_project_button_pio_if.sv
// Avalon-MM slave bus bundle for the button PIO (zero-wait-state reads).
interface nios_project_button_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios_project_button_pio_debounce.sv
// One-bit debouncer: the output follows the input only after it has differed
// for DEBOUNCE_CYCLES consecutive clocks.
module nios_project_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             f_q, f_d;

  // Any return to the accepted level restarts the count, so short glitches never commit.
  always_comb begin
    count_d = '0;
    f_d     = f_q;
    if (din != f_q) begin
      if (count_q == CNT_LAST) begin
        f_d = din;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      f_q     <= IDLE_LEVEL;
    end else begin
      count_q <= count_d;
      f_q     <= f_d;
    end
  end

  assign dout = f_q;

endmodule

// File: rtl/nios_project_button_pio.sv
// Input PIO for push-buttons: synchronizer, optional debounce (NIOS_PROJECT_BUTTON_DEBOUNCE_EN),
// sticky edge capture and a maskable level irq behind an Avalon-MM slave.
module nios_project_button_pio
  import nios_project_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  nios_project_button_pio_if.slave      bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] f_dly_q, f_dly_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

`ifdef NIOS_PROJECT_BUTTON_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    nios_project_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (s2_q[i]),
      .dout    (f[i])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign f = s2_q;
`endif

  // A clear and a fresh edge on the same bit in one cycle leave the bit set.
  always_comb begin
    s1_d      = in_port;
    s2_d      = s1_q;
    f_dly_d   = f;
    wr_en     = bus.chipselect && !bus.write_n;
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (EDGE_TYPE == EDGE_RISING) begin
      edge_det = f & ~f_dly_q;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = ~f & f_dly_q;
    end else begin
      edge_det = f ^ f_dly_q;
    end
    if (wr_en && bus.address == ADDR_IRQMASK) begin
      irqmask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && bus.address == ADDR_EDGECAP) begin
      clr_mask = bus.writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= {WIDTH{IDLE_LEVEL}};
      s2_q      <= {WIDTH{IDLE_LEVEL}};
      f_dly_q   <= {WIDTH{IDLE_LEVEL}};
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      f_dly_q   <= f_dly_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata[WIDTH-1:0] = f;
      ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecap_q;
      default:      bus.readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_project_button_pio.sv
// Directed bench for nios_project_button_pio: WIDTH=4, falling edges, idle-high inputs.
`timescale 1ns/100ps
module tb_nios_project_button_pio;

`ifdef NIOS_PROJECT_BUTTON_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;
  int         total_cnt = 0;
  int         bad_cnt   = 0;

  nios_project_button_pio_if bus ();

  nios_project_button_pio #(
    .WIDTH           (4),
    .EDGE_TYPE       (1),
    .IDLE_LEVEL      (1'b1),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.address = addr;
    #0.5;
    checkOutput(tag, bus.readdata, exp);
  endtask

  task automatic checkIrq(input string tag, input logic exp);
    #0.5;
    checkOutput(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] value);
    @(negedge clk);
    in_port = value;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    tick(2);
    reset_n = 1'b1;

    checkReg("rst_data", 2'd0, 32'h0000_000F);
    checkReg("rst_mask", 2'd2, 32'h0);
    checkReg("rst_cap", 2'd3, 32'h0);
    checkReg("rst_rsvd", 2'd1, 32'h0);
    checkIrq("rst_irq", 1'b0);

    // Falling edge on bit 0: latency to DATA and EDGECAP.
    applyStimulus(4'hE);
    tick(1 + DB);
    checkReg("data_early", 2'd0, 32'hF);
    tick(1);
    checkReg("data_late", 2'd0, 32'hE);
    checkReg("cap_early", 2'd3, 32'h0);
    tick(1);
    checkReg("cap_late", 2'd3, 32'h1);
    checkIrq("irq_masked", 1'b0);
    busWrite(2'd2, 32'h1);
    checkIrq("irq_unmask", 1'b1);
    checkReg("mask_rd", 2'd2, 32'h1);

    busWrite(2'd3, 32'h1);
    checkReg("cap_clr", 2'd3, 32'h0);
    checkIrq("irq_clr", 1'b0);

    // Rising edges are not captured in falling mode.
    applyStimulus(4'hF);
    tick(3 + DB);
    checkReg("cap_rise", 2'd3, 32'h0);
    checkReg("data_rise", 2'd0, 32'hF);

    applyStimulus(4'hC);
    tick(3 + DB);
    checkReg("cap_two", 2'd3, 32'h3);
    checkIrq("irq_two", 1'b1);
    busWrite(2'd3, 32'h0);
    checkReg("cap_w0", 2'd3, 32'h3);
    busWrite(2'd3, 32'hFFFF_FFF3);
    checkReg("cap_w1", 2'd3, 32'h0);
    checkIrq("irq_w1", 1'b0);

    busWrite(2'd2, 32'hFFFF_FFF2);
    checkReg("mask_hi", 2'd2, 32'h2);
    busWrite(2'd1, 32'hFFFF_FFFF);
    checkReg("rsvd_wr", 2'd1, 32'h0);
    checkReg("mask_keep", 2'd2, 32'h2);
    checkReg("cap_keep", 2'd3, 32'h0);

    // Clear of bit 1 lands in the same cycle as its new falling edge.
    applyStimulus(4'hF);
    tick(3 + DB);
    applyStimulus(4'hD);
    tick(1 + DB);
    busWrite(2'd3, 32'h2);
    checkReg("cap_setwins", 2'd3, 32'h2);
    checkIrq("irq_setwins", 1'b1);

    // Asynchronous reset with pending, unmasked edges.
    busWrite(2'd3, 32'hF);
    applyStimulus(4'hF);
    tick(3 + DB);
    applyStimulus(4'hA);
    tick(3 + DB);
    checkReg("cap_five", 2'd3, 32'h5);
    busWrite(2'd2, 32'hF);
    checkIrq("irq_pre_rst", 1'b1);
    #2;
    reset_n = 1'b0;
    checkIrq("irq_async", 1'b0);
    checkReg("cap_async", 2'd3, 32'h0);
    checkReg("mask_async", 2'd2, 32'h0);
    checkReg("data_async", 2'd0, 32'hF);
    checkReg("rsvd_async", 2'd1, 32'h0);
    in_port = 4'hF;
    @(negedge clk);
    reset_n = 1'b1;
    tick(4 + DB);
    checkReg("cap_post_rst", 2'd3, 32'h0);
    checkReg("data_post_rst", 2'd0, 32'hF);

`ifdef NIOS_PROJECT_BUTTON_DEBOUNCE_EN
    // A 3-cycle glitch is shorter than the debounce window.
    applyStimulus(4'hE);
    tick(2);
    applyStimulus(4'hF);
    tick(10);
    checkReg("glitch_data", 2'd0, 32'hF);
    checkReg("glitch_cap", 2'd3, 32'h0);
    applyStimulus(4'hE);
    tick(5);
    checkReg("db_data_early", 2'd0, 32'hF);
    tick(1);
    checkReg("db_data_late", 2'd0, 32'hE);
    checkReg("db_cap_early", 2'd3, 32'h0);
    tick(1);
    checkReg("db_cap_late", 2'd3, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
